// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Shares one external 23LC-style SPI RAM between a 16-bit instruction-fetch
//   port and a byte-wide data load/store port. Each access is a complete
//   READ/WRITE command: opcode, 16-bit byte address, then 16 (fetch) or
//   8 (data) data bits. Requests arriving together are granted round-robin.
// Ports
//   clk, rst                       system clock, async active-high reset
//   if_req/if_addr                 fetch request (level) and byte address
//   if_rdata/if_ready              fetched word {[addr],[addr+1]}, done pulse
//   d_req/d_we/d_addr/d_wdata      data request (level), write enable, address, write byte
//   d_rdata/d_ready                read byte, done pulse (reads and writes)
//   spi_cs/spi_sck/spi_mosi        SPI mode-0 master pins (CS active-low)
//   spi_miso                       SPI serial input (already synchronised)
//   busy                           high from grant until the ready pulse
module spi_ram_arbiter #(
  parameter int unsigned CLK_DIV    = 1,
  parameter bit          DATA_FIRST = 1'b1,
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter logic [7:0]  CMD_WRITE  = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic [7:0]  d_rdata,
  output logic        d_ready,
  output logic        spi_cs,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = $clog2(2 * CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [39:0]        sh_q, sh_d;
  logic [15:0]        rx_q, rx_d;
  logic               sel_data_q, sel_data_d;   // current grant belongs to data port
  logic               last_data_q, last_data_d; // last grant went to data port
  logic               cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d;
  logic               if_ready_q, if_ready_d, d_ready_q, d_ready_d;
  logic [15:0]        if_rdata_q, if_rdata_d;
  logic [7:0]         d_rdata_q, d_rdata_d;

  logic               grant_data_s, grant_fetch_s;
  logic [39:0]        load_s;
  logic [5:0]         last_bit_s;

  // Round-robin grant: data wins unless fetch is also pending and data went last.
  always_comb begin
    grant_data_s  = d_req & (~if_req | ~last_data_q);
    grant_fetch_s = if_req & ~grant_data_s;
    last_bit_s    = sel_data_q ? 6'd31 : 6'd39;
    // Frame is left-aligned in 40 bits; a data frame only uses the top 32.
    if (grant_data_s) begin
      load_s = {(d_we ? CMD_WRITE : CMD_READ), d_addr, (d_we ? d_wdata : 8'h00), 8'h00};
    end else begin
      load_s = {CMD_READ, if_addr, 16'h0000};
    end
  end

  // Next-state and output logic for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    gap_d       = gap_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    sel_data_d  = sel_data_q;
    last_data_d = last_data_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data_s || grant_fetch_s) begin
          state_d     = S_CMD;
          sel_data_d  = grant_data_s;
          last_data_d = grant_data_s;
          sh_d        = load_s;
          mosi_d      = load_s[39];
          cs_d        = 1'b0;
          sck_d       = 1'b0;
          busy_d      = 1'b1;
          div_d       = '0;
          bit_cnt_d   = 6'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          if (!sck_q) begin
            // Rising SCK edge: sample MISO on the same clk edge.
            sck_d = 1'b1;
            rx_d  = {rx_q[14:0], spi_miso};
          end else begin
            // Falling SCK edge ends the bit; present the next MOSI bit.
            sck_d     = 1'b0;
            sh_d      = {sh_q[38:0], 1'b0};
            mosi_d    = sh_q[38];
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == last_bit_s) begin
              state_d = S_DONE;
              mosi_d  = 1'b0;
            end else if (bit_cnt_q == 6'd7) begin
              state_d = S_ADDR;
            end else if (bit_cnt_q == 6'd23) begin
              state_d = S_DATA;
            end else begin
              state_d = state_q;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        // CS held low one extra cycle after the last SCK fall, then released.
        state_d = S_GAP;
        gap_d   = '0;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        if (sel_data_q) begin
          d_ready_d = 1'b1;
          d_rdata_d = rx_q[7:0];
        end else begin
          if_ready_d = 1'b1;
          if_rdata_d = rx_q;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_MAX) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_cnt_q   <= 6'd0;
      gap_q       <= '0;
      sh_q        <= 40'd0;
      rx_q        <= 16'h0000;
      sel_data_q  <= 1'b0;
      last_data_q <= ~DATA_FIRST;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= 16'h0000;
      d_rdata_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_q       <= gap_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      sel_data_q  <= sel_data_d;
      last_data_q <= last_data_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign spi_cs   = cs_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: a CLK_DIV=1 instance and a CLK_DIV=3
// instance share one behavioural 23LC-style RAM model through a pin mux.
module tb_spi_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // CLK_DIV=1 instance
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = 16'h0000, d_addr = 16'h0000;
  logic [7:0]  d_wdata = 8'h00;
  logic [15:0] if_rdata;
  logic [7:0]  d_rdata;
  logic        if_ready, d_ready, cs1, sck1, mosi1, busy1;
  // CLK_DIV=3 instance
  logic        if_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
  logic [15:0] if_addr3 = 16'h0000, d_addr3 = 16'h0000;
  logic [7:0]  d_wdata3 = 8'h00;
  logic [15:0] if_rdata3;
  logic [7:0]  d_rdata3;
  logic        if_ready3, d_ready3, cs3, sck3, mosi3, busy3;

  logic miso = 1'b0;
  logic sel3 = 1'b0;

  spi_ram_arbiter #(.CLK_DIV(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .spi_cs(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso), .busy(busy1)
  );

  spi_ram_arbiter #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ready(if_ready3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_rdata(d_rdata3), .d_ready(d_ready3),
    .spi_cs(cs3), .spi_sck(sck3), .spi_mosi(mosi3), .spi_miso(miso), .busy(busy3)
  );

  wire m_cs   = sel3 ? cs3   : cs1;
  wire m_sck  = sel3 ? sck3  : sck1;
  wire m_mosi = sel3 ? mosi3 : mosi1;

  // RAM model: 8-bit opcode, 16-bit address, then sequential data bytes.
  logic [7:0]  ram [0:65535];
  int          m_cnt = 0;
  logic [7:0]  m_cmd = 8'h00, m_rx = 8'h00, m_out = 8'h00;
  logic [15:0] m_addr = 16'h0000, m_addr_cap = 16'h0000;

  always @(negedge m_cs) m_cnt = 0;

  always @(posedge m_sck) begin
    if (!m_cs) begin
      if (m_cnt < 8) begin
        m_cmd = {m_cmd[6:0], m_mosi};
      end else if (m_cnt < 24) begin
        m_addr = {m_addr[14:0], m_mosi};
        if (m_cnt == 23) m_addr_cap = m_addr;
      end else if (m_cmd == 8'h02) begin
        m_rx = {m_rx[6:0], m_mosi};
        if (((m_cnt - 24) % 8) == 7) begin
          ram[m_addr] = m_rx;
          m_addr = m_addr + 16'd1;
        end
      end
      m_cnt = m_cnt + 1;
    end
  end

  always @(negedge m_sck) begin
    if (!m_cs && m_cnt >= 24 && m_cmd == 8'h03) begin
      if (((m_cnt - 24) % 8) == 0) begin
        m_out  = ram[m_addr];
        m_addr = m_addr + 16'd1;
      end
      miso  = m_out[7];
      m_out = {m_out[6:0], 1'b0};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_wait();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // which: 0 = fetch (div1), 1 = data (div1), 2 = data (div3). Returns edges counted.
  task automatic wait_ready(input int which, input int budget, output int n);
    logic got;
    logic bsy;
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      case (which)
        0:       begin got = if_ready; bsy = busy1; end
        1:       begin got = d_ready;  bsy = busy1; end
        default: begin got = d_ready3; bsy = busy3; end
      endcase
      if (n == 1) chk("busy_after_grant", bsy, 1'b1);
    end
    chk("ready_seen", got, 1'b1);
  endtask

  task automatic do_fetch(input logic [15:0] a, input logic [15:0] exp);
    int n;
    if_addr = a;
    if_req  = 1'b1;
    wait_ready(0, 400, n);
    if_req = 1'b0;
    chk("if_latency", n, 82);
    chk("if_rdata", if_rdata, exp);
    chk("if_cmd", m_cmd, 8'h03);
    chk("if_addr_sent", m_addr_cap, a);
    chk("busy_at_ready", busy1, 1'b0);
    idle_wait();
  endtask

  task automatic do_data(input logic we, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd);
    int n;
    d_we = we; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    wait_ready(1, 400, n);
    d_req = 1'b0;
    chk("d_latency", n, 66);
    chk("d_cmd", m_cmd, we ? 8'h02 : 8'h03);
    chk("d_addr_sent", m_addr_cap, a);
    if (we) chk("ram_written", ram[a], wd);
    else    chk("d_rdata", d_rdata, exp_rd);
    idle_wait();
  endtask

  initial begin
    int n, hi, run, hi_min, hi_max, lo_min, lo_max;
    logic prev, got;
    logic [3:0] ord;
    int nord;
    logic both;

    ram[16'h0010] = 8'hAB; ram[16'h0011] = 8'hCD;
    ram[16'hFFFF] = 8'h12; ram[16'h0000] = 8'h34;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", cs1, 1'b1);
    chk("rst_sck", sck1, 1'b0);
    chk("rst_mosi", mosi1, 1'b0);
    chk("rst_ready", {if_ready, d_ready}, 2'b00);
    chk("rst_rdata", {if_rdata, d_rdata}, 24'h000000);
    chk("rst_busy", busy1, 1'b0);
    rst = 1'b0;
    idle_wait();

    do_fetch(16'h0010, 16'hABCD);
    do_data(1'b1, 16'h0102, 8'h5A, 8'h00);
    do_data(1'b0, 16'h0102, 8'h00, 8'h5A);
    do_fetch(16'hFFFF, 16'h1234);
    chk("if_rdata_hold", if_rdata, 16'h1234);

    // Simultaneous requests after reset: data first, then alternate.
    rst = 1'b1; #1; rst = 1'b0;
    idle_wait();
    d_we = 1'b0; d_addr = 16'h0102; if_addr = 16'h0010;
    if_req = 1'b1; d_req = 1'b1;
    ord = 4'b0000; nord = 0; both = 1'b0; n = 0;
    while (nord < 4 && n < 800) begin
      @(posedge clk); #1; n++;
      if (if_ready && d_ready) both = 1'b1;
      if (d_ready || if_ready) begin
        ord[nord] = d_ready;
        nord++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("rr_count", nord, 4);
    chk("rr_order", ord, 4'b0101);
    chk("rr_no_double_ready", both, 1'b0);
    chk("rr_if_rdata", if_rdata, 16'hABCD);
    chk("rr_d_rdata", d_rdata, 8'h5A);
    idle_wait();

    // Reset during the address phase, then a clean fetch.
    if_addr = 16'h0010; if_req = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_cs", cs1, 1'b1);
    chk("midrst_sck", sck1, 1'b0);
    chk("midrst_busy", busy1, 1'b0);
    if_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_wait();
    do_fetch(16'h0010, 16'hABCD);

    // CLK_DIV=3 data read with SCK phase measurement.
    sel3 = 1'b1;
    d_addr3 = 16'h0102; d_we3 = 1'b0;
    d_req3 = 1'b1;
    n = 0; got = 1'b0; prev = 1'b0; run = 0;
    hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    while (!got && n < 600) begin
      @(posedge clk); #1; n++;
      got = d_ready3;
      if (sck3 == prev) begin
        run++;
      end else begin
        if (prev) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end else if (!cs3) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        run = 1;
        prev = sck3;
      end
    end
    chk("div3_ready_seen", got, 1'b1);
    chk("div3_latency", n, 194);
    chk("div3_rdata", d_rdata3, 8'h5A);
    chk("div3_sck_high", {hi_min[7:0], hi_max[7:0]}, 16'h0303);
    chk("div3_sck_low", {lo_min[7:0], lo_max[7:0]}, 16'h0303);
    // Request left high: counted as a new request after the CS gap.
    hi = 0;
    n = 0;
    while (cs3 && n < 60) begin
      hi++;
      @(posedge clk); #1; n++;
    end
    chk("div3_cs_gap_ge6", (hi >= 6), 1'b1);
    wait_ready(2, 600, n);
    d_req3 = 1'b0;
    chk("div3_second_rdata", d_rdata3, 8'h5A);
    idle_wait();
    sel3 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
